// File: rtl/ifetch_buffer.sv
// Fetch stage: DEPTH-entry prefetch FIFO between IRAM and decode, with startup flush and branch redirect.
// Optional zero-bubble bypass of an empty FIFO is enabled by defining IFETCH_BYPASS_EN.
module ifetch_buffer #(
    parameter int                DATA_W       = 32,
    parameter int                DEPTH        = 4,
    parameter int                FLUSH_CYCLES = 6,
    parameter logic [DATA_W-1:0] NOP          = '0,
    localparam int               AW           = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Inst,
    input  logic              IValid,
    input  logic              Stall,
    input  logic              Redirect,
    output logic              IRead,
    output logic [DATA_W-1:0] Fetched,
    output logic              Flush,
    output logic [AW:0]       Level
);

    localparam int FW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       level_q;
    logic              drop;
    logic              flush_q;
    logic [FW-1:0]     flush_cnt;
    logic [DATA_W-1:0] fetched_q;

    logic push_req;
    logic pop_en;
    logic redirect_en;
    logic empty;
    logic full;
    logic bypass;
    logic wr_en;
    logic rd_en;

    always_comb begin
        redirect_en = Redirect & ~flush_q;
        push_req    = IValid & ~flush_q & ~Redirect & ~drop;
        pop_en      = ~Stall & ~flush_q & ~Redirect;
        empty       = (level_q == '0);
        full        = (level_q == (AW+1)'(DEPTH));
`ifdef IFETCH_BYPASS_EN
        bypass      = pop_en & empty & push_req;
`else
        bypass      = 1'b0;
`endif
        // A push into a full FIFO only happens with an out-of-protocol IRAM; that word is lost.
        wr_en       = push_req & ~bypass & ~full;
        rd_en       = pop_en & ~empty;
    end

    // Flush counts posedges after Reset falls, then stays low until the next Reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            flush_q   <= 1'b1;
            flush_cnt <= '0;
        end else if (flush_q) begin
            if (flush_cnt == FW'(FLUSH_CYCLES - 1)) begin
                flush_q <= 1'b0;
            end else begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level_q   <= '0;
            drop      <= 1'b0;
            fetched_q <= NOP;
        end else if (!flush_q) begin
            if (redirect_en) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                level_q   <= '0;
                drop      <= 1'b1;
                fetched_q <= NOP;
            end else begin
                // The stale in-flight response is the only word the drop flag swallows.
                drop    <= 1'b0;
                level_q <= level_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (pop_en) begin
                    if (bypass) begin
                        fetched_q <= Inst;
                    end else if (rd_en) begin
                        fetched_q <= mem[rd_ptr];
                    end else begin
                        fetched_q <= NOP;
                    end
                end
            end
        end
    end

    // NOTE: the storage array has no reset; Level and the pointers define which entries are valid.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= Inst;
        end
    end

    // One slot stays reserved for the word already requested but not yet returned.
    assign IRead   = ~flush_q & ~Redirect & (level_q <= (AW+1)'(DEPTH - 2));
    assign Fetched = fetched_q;
    assign Flush   = flush_q;
    assign Level   = level_q;

endmodule
